// File: rtl/deserializador.sv
// Serial-to-parallel byte receiver with a consumer acknowledge handshake.
// Bit order: MSB-first by default; define DESER_LSB_FIRST_EN for LSB-first.
module deserializador (
  input  logic       clock_100KHz,
  input  logic       reset,
  input  logic       data_in,
  input  logic       write_in,
  input  logic       ack_in,
  output logic       status_out,
  output logic       data_ready,
  output logic [7:0] data_out
);

  typedef enum logic {
    RECEIVE  = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  bits_count_q, bits_count_d;
  logic [7:0]  shift_in;

  always_comb begin
`ifdef DESER_LSB_FIRST_EN
    shift_in = {data_in, shift_q[7:1]};
`else
    shift_in = {shift_q[6:0], data_in};
`endif
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    data_d       = data_q;
    bits_count_d = bits_count_q;
    case (state_q)
      RECEIVE: begin
        if (write_in) begin
          shift_d      = shift_in;
          bits_count_d = bits_count_q + 4'd1;
          // The 8th bit goes straight into data_out on the same edge.
          if (bits_count_q == 4'd7) begin
            data_d  = shift_in;
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (ack_in) begin
          bits_count_d = '0;
          shift_d      = '0;
          state_d      = RECEIVE;
        end
      end
      default: state_d = RECEIVE;
    endcase
  end

  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      state_q      <= RECEIVE;
      shift_q      <= '0;
      data_q       <= '0;
      bits_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      bits_count_q <= bits_count_d;
    end
  end

  assign status_out = (state_q == RECEIVE);
  assign data_ready = (state_q == WAIT_ACK);
  assign data_out   = data_q;

endmodule

// File: tb/tb_deserializador.sv
// Directed bench for deserializador: a behavioural model plus a byte
// scoreboard checked on every clock of the stimulus sequence.
module tb_deserializador;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic       write_in = 1'b0;
  logic       ack_in = 1'b0;
  logic       status_out;
  logic       data_ready;
  logic [7:0] data_out;

  int tests  = 0;
  int failed = 0;

  logic [7:0] exp_q[$];
  logic       m_recv = 1'b1;
  int         m_cnt = 0;
  logic [7:0] m_shift = '0;
  logic [7:0] m_dout = '0;
  logic       prev_ready = 1'b0;

`ifdef DESER_LSB_FIRST_EN
  localparam logic [7:0] GAP_BYTE = 8'hAA;
`else
  localparam logic [7:0] GAP_BYTE = 8'h55;
`endif

  deserializador dut (
    .clock_100KHz(clk),
    .reset       (reset),
    .data_in     (data_in),
    .write_in    (write_in),
    .ack_in      (ack_in),
    .status_out  (status_out),
    .data_ready  (data_ready),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic w, input logic d, input logic a, input logic r);
    reset    = r;
    write_in = w;
    data_in  = d;
    ack_in   = a;
    if (r) begin
      m_recv = 1'b1; m_cnt = 0; m_shift = '0; m_dout = '0;
    end else if (m_recv) begin
      if (w) begin
        m_cnt++;
`ifdef DESER_LSB_FIRST_EN
        m_shift = {d, m_shift[7:1]};
`else
        m_shift = {m_shift[6:0], d};
`endif
        if (m_cnt == 8) begin
          m_dout = m_shift;
          exp_q.push_back(m_shift);
          m_recv = 1'b0;
        end
      end
    end else if (a) begin
      m_recv = 1'b1;
      m_cnt  = 0;
    end
    @(posedge clk);
    #1;
    chk("status_out", {31'd0, status_out}, {31'd0, m_recv});
    chk("data_ready", {31'd0, data_ready}, {31'd0, ~m_recv});
    chk("bits_count", {28'd0, dut.bits_count_q}, m_cnt);
    chk("data_out",   {24'd0, data_out}, {24'd0, m_dout});
    if (data_ready && !prev_ready) begin
      if (exp_q.size() > 0) chk("sb_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      else chk("sb_unexpected_byte", {24'd0, data_out}, 32'hFFFF_FFFF);
    end
    prev_ready = data_ready;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
`ifdef DESER_LSB_FIRST_EN
      step(1'b1, b[i], 1'b0, 1'b0);
`else
      step(1'b1, b[7-i], 1'b0, 1'b0);
`endif
    end
  endtask

  initial begin
    logic [7:0] rnd;

    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_data_out", {24'd0, data_out}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Gapped byte: 0,1,0, gap of 2 with data_in=1, then 1,0,1,0,1
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("gap_byte_value", {24'd0, data_out}, {24'd0, GAP_BYTE});
    chk("gap_ready", {31'd0, data_ready}, 32'd1);

    // Writes ignored while waiting for ack
    for (int i = 0; i < 4; i++) step(1'b1, i[0], 1'b0, 1'b0);
    chk("wait_hold_data", {24'd0, data_out}, {24'd0, GAP_BYTE});
    chk("wait_hold_count", {28'd0, dut.bits_count_q}, 32'd8);

    // Ack held two cycles: one acknowledge, data_out kept
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ack_ready_low", {31'd0, data_ready}, 32'd0);
    chk("ack_keep_data", {24'd0, data_out}, {24'd0, GAP_BYTE});
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(8'hFF);
    chk("ff_byte", {24'd0, data_out}, 32'hFF);

    // Simultaneous ack and write: bit dropped
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("ack_write_count", {28'd0, dut.bits_count_q}, 32'd0);

    // Ack in RECEIVE mid-byte has no effect
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Random byte
    rnd = 8'($urandom);
    send_byte(rnd);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-byte after 5 bits, then a full byte
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("midreset_count", {28'd0, dut.bits_count_q}, 32'd0);
    chk("midreset_data", {24'd0, data_out}, 32'd0);
    send_byte(8'hC3);

    // Reset while waiting for ack discards the byte
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("waitreset_ready", {31'd0, data_ready}, 32'd0);
    send_byte(8'h3A);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
